goomba_collision_resolver: RTL

Consumes goomba_x/goomba_y from the Goomba mover and Mario's position and fall state from the Mario mover, once per movement tick. Decides whether Mario stomped the Goomba or was hit by it, and tracks the Goomba life cycle: ALIVE, then SQUISHED, then DEAD. Drives the sprite renderer (visible/squished flags) and game control (stomp/hit pulses).

---
 rtl/goomba_collision_resolver_pkg.sv | 32 +++
 rtl/goomba_collision_resolver_if.sv | 27 ++
 rtl/goomba_collision_resolver_tick_down_counter.sv | 37 +++
 rtl/goomba_collision_resolver.sv | 133 +++++++++++++
 4 files changed

// File: rtl/goomba_collision_resolver_pkg.sv
// Shared game definitions: Goomba life-cycle states, sprite geometry
// defaults and a reusable axis-aligned box overlap test.
package goomba_collision_resolver_pkg;

    typedef enum logic [1:0] {
        ALIVE    = 2'd0,
        SQUISHED = 2'd1,
        DEAD     = 2'd2
    } goomba_state_t;

    localparam int DEFAULT_CHARACTER_WIDTH    = 42;
    localparam int DEFAULT_STOMP_MARGIN       = 8;
    localparam int DEFAULT_SQUISH_TICKS       = 30;
    localparam int DEFAULT_HIT_COOLDOWN_TICKS = 60;

    // Two square boxes of edge w overlap when they intersect on both axes;
    // touching edges do not count.
    function automatic logic box_overlap(
        input logic signed [31:0] ax,
        input logic signed [31:0] ay,
        input logic signed [31:0] bx,
        input logic signed [31:0] by,
        input int                 w
    );
        logic h_ovl;
        logic v_ovl;
        h_ovl = (ax < bx + w) && (bx < ax + w);
        v_ovl = (ay < by + w) && (by < ay + w);
        return h_ovl && v_ovl;
    endfunction

endpackage

// File: rtl/goomba_collision_resolver_if.sv
// Bus between the game logic (movers, renderer, game control) and the
// Goomba collision resolver.
interface goomba_collision_resolver_if;

    logic               movement_tick;
    logic signed [31:0] mario_x;
    logic signed [31:0] mario_y;
    logic               mario_falling;
    logic signed [31:0] goomba_x;
    logic signed [31:0] goomba_y;
    logic               goomba_visible;
    logic               goomba_squished;
    logic               goomba_active;
    logic               stomp_pulse;
    logic               mario_hit_pulse;

    modport master (
        output movement_tick, mario_x, mario_y, mario_falling, goomba_x, goomba_y,
        input  goomba_visible, goomba_squished, goomba_active, stomp_pulse, mario_hit_pulse
    );

    modport slave (
        input  movement_tick, mario_x, mario_y, mario_falling, goomba_x, goomba_y,
        output goomba_visible, goomba_squished, goomba_active, stomp_pulse, mario_hit_pulse
    );

endinterface

// File: rtl/goomba_collision_resolver_tick_down_counter.sv
// Loadable down counter that saturates at zero and reports when it is empty.
module tick_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load has priority; decrement stops at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/goomba_collision_resolver.sv
// Decides stomp versus hit between Mario and the Goomba once per movement
// tick and runs the Goomba ALIVE -> SQUISHED -> DEAD life cycle.
module goomba_collision_resolver
    import goomba_collision_resolver_pkg::*;
#(
    parameter int CHARACTER_WIDTH    = DEFAULT_CHARACTER_WIDTH,
    parameter int STOMP_MARGIN       = DEFAULT_STOMP_MARGIN,
    parameter int SQUISH_TICKS       = DEFAULT_SQUISH_TICKS,
    parameter int HIT_COOLDOWN_TICKS = DEFAULT_HIT_COOLDOWN_TICKS
) (
    input logic                        vga_clock,
    input logic                        reset,
    goomba_collision_resolver_if.slave bus
);

    localparam int MAX_TICKS = (SQUISH_TICKS > HIT_COOLDOWN_TICKS) ? SQUISH_TICKS : HIT_COOLDOWN_TICKS;
    localparam int CW        = $clog2(MAX_TICKS) + 1;

    localparam logic [CW-1:0] SQUISH_LOAD   = CW'(SQUISH_TICKS - 1);
    localparam logic [CW-1:0] COOLDOWN_LOAD = CW'(HIT_COOLDOWN_TICKS - 1);

    if (SQUISH_TICKS < 1) begin : g_bad_squish_ticks
        $error("SQUISH_TICKS must be at least 1");
    end
    if (HIT_COOLDOWN_TICKS < 1) begin : g_bad_cooldown_ticks
        $error("HIT_COOLDOWN_TICKS must be at least 1");
    end

    goomba_state_t state_q, state_d;
    logic          visible_q, visible_d;
    logic          squished_q, squished_d;
    logic          active_q, active_d;
    logic          stomp_q, stomp_d;
    logic          hit_q, hit_d;

    logic contact;
    logic stomp_cond;
    logic sq_load, sq_dec, sq_zero;
    logic cd_load, cd_dec, cd_zero;

    // Geometry of this tick's positions.
    always_comb begin
        contact    = box_overlap(bus.mario_x, bus.mario_y, bus.goomba_x, bus.goomba_y, CHARACTER_WIDTH);
        stomp_cond = contact && bus.mario_falling &&
                     ((bus.mario_y + CHARACTER_WIDTH) <= (bus.goomba_y + STOMP_MARGIN));
    end

    tick_down_counter #(.WIDTH(CW)) u_squish_cnt (
        .clk_i      (vga_clock),
        .rst_i      (reset),
        .load_i     (sq_load),
        .load_val_i (SQUISH_LOAD),
        .dec_i      (sq_dec),
        .zero_o     (sq_zero)
    );

    tick_down_counter #(.WIDTH(CW)) u_cooldown_cnt (
        .clk_i      (vga_clock),
        .rst_i      (reset),
        .load_i     (cd_load),
        .load_val_i (COOLDOWN_LOAD),
        .dec_i      (cd_dec),
        .zero_o     (cd_zero)
    );

    // Next state, counter controls and next registered outputs.
    always_comb begin
        state_d = state_q;
        stomp_d = 1'b0;
        hit_d   = 1'b0;
        sq_load = 1'b0;
        sq_dec  = 1'b0;
        cd_load = 1'b0;
        // Cooldown only reloads when already empty, so load and decrement never clash.
        cd_dec  = bus.movement_tick && !cd_zero;
        if (bus.movement_tick) begin
            unique case (state_q)
                ALIVE: begin
                    if (stomp_cond) begin
                        state_d = SQUISHED;
                        stomp_d = 1'b1;
                        sq_load = 1'b1;
                    end else if (contact && cd_zero) begin
                        hit_d   = 1'b1;
                        cd_load = 1'b1;
                    end
                end
                SQUISHED: begin
                    if (sq_zero) begin
                        state_d = DEAD;
                    end else begin
                        sq_dec = 1'b1;
                    end
                end
                DEAD: begin
                    state_d = DEAD;
                end
                default: begin
                    state_d = ALIVE;
                end
            endcase
        end
        visible_d  = (state_d != DEAD);
        squished_d = (state_d == SQUISHED);
        active_d   = (state_d == ALIVE);
    end

    // State and output registers.
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            state_q    <= ALIVE;
            visible_q  <= 1'b1;
            squished_q <= 1'b0;
            active_q   <= 1'b1;
            stomp_q    <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            visible_q  <= visible_d;
            squished_q <= squished_d;
            active_q   <= active_d;
            stomp_q    <= stomp_d;
            hit_q      <= hit_d;
        end
    end

    assign bus.goomba_visible  = visible_q;
    assign bus.goomba_squished = squished_q;
    assign bus.goomba_active   = active_q;
    assign bus.stomp_pulse     = stomp_q;
    assign bus.mario_hit_pulse = hit_q;

endmodule
